// File: rtl/match_log_pkg.sv
// Shared types and helpers for the match event logger.
// Build option MATCH_LOG_DROP_CNT_EN (in match_event_logger) adds a dropped-record counter.
package match_log_pkg;

  localparam int unsigned TS_W_DEF  = 16;
  localparam int unsigned CNT_W_DEF = 16;

  // Record fields are sized for the default widths; narrower builds zero-extend.
  typedef struct packed {
    logic [TS_W_DEF-1:0]  ts;
    logic [CNT_W_DEF-1:0] seq;
  } match_rec_t;

  // Increment that holds at limit instead of wrapping.
  function automatic logic [CNT_W_DEF-1:0] sat_inc(input logic [CNT_W_DEF-1:0] value,
                                                   input logic [CNT_W_DEF-1:0] limit);
    return (value >= limit) ? limit : value + CNT_W_DEF'(1);
  endfunction

endpackage

// File: rtl/match_log_fifo.sv
// Synchronous FIFO of match records; head is read combinationally from storage.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module match_log_fifo
  import match_log_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  match_rec_t       wdata,
  output match_rec_t       rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  match_rec_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/match_event_logger.sv
// Timestamps detector match pulses into a FIFO drained over valid/ready.
// Define MATCH_LOG_DROP_CNT_EN to add the saturating drop_cnt output.
module match_event_logger
  import match_log_pkg::*;
#(
  parameter  int unsigned TS_W  = TS_W_DEF,
  parameter  int unsigned CNT_W = CNT_W_DEF,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             match,
  input  logic             en,
  input  logic             clr,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [TS_W-1:0]  evt_ts,
  output logic [CNT_W-1:0] evt_seq,
  output logic [CNT_W-1:0] match_cnt,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow
`ifdef MATCH_LOG_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0] drop_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [TS_W-1:0]  ts_q;
  logic [CNT_W-1:0] seq_q;
  logic             accept;
  logic             pop;
  logic             full;
  logic             empty;
  logic             drop;
  match_rec_t       wr_rec;
  match_rec_t       head;

  assign accept = match && en && !clr;
  assign pop    = evt_valid && evt_ready;
  assign drop   = accept && full && !pop;

  always_comb begin
    wr_rec     = '0;
    wr_rec.ts  = TS_W_DEF'(ts_q);
    wr_rec.seq = CNT_W_DEF'(seq_q);
  end

  match_log_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .flush (clr),
    .wdata (wr_rec),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // Head fields read as zero when nothing is queued, so reset values are clean.
  assign evt_valid = !empty;
  assign evt_ts    = empty ? '0 : TS_W'(head.ts);
  assign evt_seq   = empty ? '0 : CNT_W'(head.seq);

  // Free-running timestamp; clr deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + TS_W'(1);
  end

  // seq advances on every accepted match, even a dropped one, exposing gaps.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      seq_q     <= '0;
      match_cnt <= '0;
      overflow  <= 1'b0;
    end else if (accept) begin
      seq_q     <= seq_q + CNT_W'(1);
      match_cnt <= CNT_W'(sat_inc(CNT_W_DEF'(match_cnt), CNT_W_DEF'(CNT_MAX)));
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef MATCH_LOG_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || clr) drop_cnt <= '0;
    else if (drop)  drop_cnt <= CNT_W'(sat_inc(CNT_W_DEF'(drop_cnt), CNT_W_DEF'(CNT_MAX)));
  end
`endif

endmodule

// File: tb/tb_match_event_logger.sv
// Randomized and directed bench for match_event_logger: a default-width instance
// and a narrow (TS_W=4, CNT_W=4, DEPTH=4) instance share stimulus against a queue model.
module tb_match_event_logger;

  logic clk = 1'b0;
  logic rst, match, en, clr, evt_ready;

  logic        a_valid, b_valid;
  logic [15:0] a_ts, a_seq, a_cnt;
  logic [3:0]  a_lvl;
  logic        a_ovf, b_ovf;
  logic [3:0]  b_ts, b_seq, b_cnt;
  logic [2:0]  b_lvl;
`ifdef MATCH_LOG_DROP_CNT_EN
  logic [15:0] a_drop;
  logic [3:0]  b_drop;
`endif

  int errors = 0;
  int checks = 0;

  int tsmod [2];
  int cmax  [2];
  int depth [2];
  int m_ts  [2];
  int m_seq [2];
  int m_cnt [2];
  int m_drop[2];
  bit m_ovf [2];
  int qts   [2][$];
  int qsq   [2][$];

  always #5 clk = ~clk;

  match_event_logger u_a (
    .clk(clk), .rst(rst), .match(match), .en(en), .clr(clr),
    .evt_valid(a_valid), .evt_ready(evt_ready), .evt_ts(a_ts), .evt_seq(a_seq),
    .match_cnt(a_cnt), .fifo_level(a_lvl), .overflow(a_ovf)
`ifdef MATCH_LOG_DROP_CNT_EN
    , .drop_cnt(a_drop)
`endif
  );

  match_event_logger #(.TS_W(4), .CNT_W(4), .DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .match(match), .en(en), .clr(clr),
    .evt_valid(b_valid), .evt_ready(evt_ready), .evt_ts(b_ts), .evt_seq(b_seq),
    .match_cnt(b_cnt), .fifo_level(b_lvl), .overflow(b_ovf)
`ifdef MATCH_LOG_DROP_CNT_EN
    , .drop_cnt(b_drop)
`endif
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference behaviour for one clock edge, using the inputs present at that edge.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit do_pop;
      int ts_old;
      do_pop = (qts[k].size() > 0) && evt_ready;
      ts_old = m_ts[k];
      if (rst) begin
        m_ts[k] = 0; m_seq[k] = 0; m_cnt[k] = 0; m_drop[k] = 0; m_ovf[k] = 0;
        qts[k].delete(); qsq[k].delete();
      end else begin
        m_ts[k] = (m_ts[k] + 1) % tsmod[k];
        if (clr) begin
          m_seq[k] = 0; m_cnt[k] = 0; m_drop[k] = 0; m_ovf[k] = 0;
          qts[k].delete(); qsq[k].delete();
        end else begin
          if (do_pop) begin
            void'(qts[k].pop_front());
            void'(qsq[k].pop_front());
          end
          if (match && en) begin
            if (m_cnt[k] < cmax[k]) m_cnt[k]++;
            if (qts[k].size() < depth[k]) begin
              qts[k].push_back(ts_old);
              qsq[k].push_back(m_seq[k]);
            end else begin
              m_ovf[k] = 1'b1;
              if (m_drop[k] < cmax[k]) m_drop[k]++;
            end
            m_seq[k] = (m_seq[k] + 1) % (cmax[k] + 1);
          end
        end
      end
    end
  endtask

  task automatic check_inst(input int k, input logic v, input longint ts, input longint seq,
                            input longint cnt, input longint lvl, input logic ovf,
                            input longint drop);
    check($sformatf("i%0d_valid", k), longint'(v), longint'(qts[k].size() > 0));
    if (qts[k].size() > 0) begin
      check($sformatf("i%0d_ts", k), ts, longint'(qts[k][0]));
      check($sformatf("i%0d_seq", k), seq, longint'(qsq[k][0]));
    end
    check($sformatf("i%0d_cnt", k), cnt, longint'(m_cnt[k]));
    check($sformatf("i%0d_level", k), lvl, longint'(qts[k].size()));
    check($sformatf("i%0d_ovf", k), longint'(ovf), longint'(m_ovf[k]));
`ifdef MATCH_LOG_DROP_CNT_EN
    check($sformatf("i%0d_drop", k), drop, longint'(m_drop[k]));
`else
    if (drop != 0) check($sformatf("i%0d_drop", k), drop, 0);
`endif
  endtask

  task automatic check_all();
    longint da, db;
`ifdef MATCH_LOG_DROP_CNT_EN
    da = longint'(a_drop);
    db = longint'(b_drop);
`else
    da = 0;
    db = 0;
`endif
    check_inst(0, a_valid, longint'(a_ts), longint'(a_seq), longint'(a_cnt),
               longint'(a_lvl), a_ovf, da);
    check_inst(1, b_valid, longint'(b_ts), longint'(b_seq), longint'(b_cnt),
               longint'(b_lvl), b_ovf, db);
  endtask

  task automatic step(input bit m, input bit e, input bit c, input bit r, input bit rs);
    match = m; en = e; clr = c; evt_ready = r; rst = rs;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    tsmod = '{65536, 16};
    cmax  = '{65535, 15};
    depth = '{8, 4};
    foreach (m_ts[k]) begin
      m_ts[k] = 0; m_seq[k] = 0; m_cnt[k] = 0; m_drop[k] = 0; m_ovf[k] = 0;
    end
    rst = 1'b1; match = 1'b0; en = 1'b0; clr = 1'b0; evt_ready = 1'b0;

    // Reset state
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("rst_ts", longint'(a_ts), 0);
    check("rst_seq", longint'(a_seq), 0);
    check("rst_valid", longint'(a_valid), 0);

    // Single match at ts=5
    for (int i = 0; i < 100 && m_ts[0] != 5; i++) step(0, 1, 0, 0, 0);
    check("reach_ts5", m_ts[0], 5);
    step(1, 1, 0, 0, 0);
    check("single_valid", longint'(a_valid), 1);
    check("single_ts", longint'(a_ts), 5);
    check("single_seq", longint'(a_seq), 0);
    check("single_cnt", longint'(a_cnt), 1);

    // Fill and overflow
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
    check("fill_level", longint'(a_lvl), 8);
    check("fill_ovf", longint'(a_ovf), 1);
    check("fill_cnt", longint'(a_cnt), 10);
    check("fill_head", longint'(a_seq), 0);
`ifdef MATCH_LOG_DROP_CNT_EN
    check("fill_drop", longint'(a_drop), 2);
`endif
    for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 0);
    check("drain_empty", longint'(a_valid), 0);

    // Full FIFO with simultaneous push and pop
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    check("pp_level", longint'(a_lvl), 8);
    check("pp_ovf", longint'(a_ovf), 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 1, 0);
    check("pp_last", longint'(a_seq), 8);
    step(0, 1, 0, 1, 0);

    // Gating by en and clr
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    check("gate_valid", longint'(a_valid), 0);
    check("gate_cnt", longint'(a_cnt), 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    check("clr_level", longint'(a_lvl), 0);
    check("clr_cnt", longint'(a_cnt), 0);
    step(1, 1, 0, 0, 0);
    check("clr_seq", longint'(a_seq), 0);

    // Narrow instance: ts and seq wrap, count saturates
    step(0, 1, 1, 1, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 1, 0);
    check("sat_cnt", longint'(b_cnt), 15);
    check("sat_ovf", longint'(b_ovf), 0);

    // Reset mid-operation with a pending handshake
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    check("mid_valid_pre", longint'(a_valid), 1);
    step(1, 1, 0, 0, 1);
    check("mid_valid", longint'(a_valid), 0);
    check("mid_level", longint'(a_lvl), 0);
    check("mid_ovf", longint'(a_ovf), 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(99) < 60), ($urandom_range(99) < 85), ($urandom_range(99) < 2),
           ($urandom_range(99) < 45), ($urandom_range(999) < 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/match_event_logger.md
# match_event_logger

Downstream consumer of the serial sequence-detector's one-cycle match pulse. Stamps every accepted match with a free-running cycle timestamp and a sequence index, and buffers the records in a small FIFO. Software or a bus bridge drains the FIFO over a valid/ready interface. Also keeps a saturating total match count and a sticky overflow flag.

## Interface
- TS_W, 16: timestamp width; free-running counter wraps modulo 2^TS_W.
- CNT_W, 16: width of match count and sequence index.
- DEPTH, 8: FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  single clock; everything is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- match  in  1  detector output pulse; 1 = sequence completed this cycle.
- en  in  1  logging enable; match ignored entirely when 0.
- clr  in  1  synchronous clear of counts, flags and FIFO contents.
- evt_valid  out  1  head record available.
- evt_ready  in  1  consumer accepts head record.
- evt_ts  out  TS_W  timestamp of head record.
- evt_seq  out  CNT_W  sequence index of head record.
- match_cnt  out  CNT_W  total accepted matches, saturating.
- fifo_level  out  $clog2(DEPTH)+1  entries currently stored.
- overflow  out  1  sticky; a match was dropped because the FIFO was full.

## Operation
- ts counter: +1 every cycle, including while en=0. Wraps from 2^TS_W−1 to 0. Not affected by clr.
- Accepted match: match=1 and en=1 and clr=0.
- On an accepted match:
  - match_cnt increments, holding at 2^CNT_W−1.
  - seq increments, wrapping.
  - A push of {ts, seq} is attempted, using the pre-increment ts and seq.
- First accepted match after reset/clr has evt_seq=0. The seq value is consumed even when the push is dropped, so gaps in evt_seq reveal drops.
- Push when full:
  - If a pop happens in the same cycle, the push is accepted and the level is unchanged.
  - Otherwise the record is dropped and overflow is set.
- Pop: evt_valid && evt_ready.
- evt_ts and evt_seq are stable while evt_valid && !evt_ready.
- Empty FIFO: evt_valid=0; evt_ts and evt_seq are don't-care.
- clr: flushes the FIFO and zeroes match_cnt, seq, overflow and the drop count. clr has priority over a simultaneous match and a simultaneous pop.
- Reset values: evt_valid=0, evt_ts=0, evt_seq=0, match_cnt=0, fifo_level=0, overflow=0, ts=0.

## Timing
- Match at cycle N with ts=T is visible at the earliest as evt_valid=1, evt_ts=T in cycle N+1. There is no same-cycle fall-through.
- fifo_level, match_cnt and overflow update at the clock edge following the event.
- Back-to-back matches (every cycle) are all logged while space remains. With evt_ready held at 1, the sustained rate is one record per cycle with no loss.
- rst asserted mid-operation: all state returns to reset values at that edge. evt_valid=0 from the next cycle, even if a handshake was pending.

## Configuration
- MATCH_LOG_DROP_CNT_EN:
  - Defined: adds output drop_cnt (CNT_W), counting dropped records. It saturates at 2^CNT_W−1 and is cleared by rst and clr.
  - Undefined: the port and counter are absent; only sticky overflow reports loss.

## Structure
- Package match_log_pkg holds:
  - TS_W_DEF and CNT_W_DEF constants.
  - Typedef match_rec_t {ts, seq}.
  - A saturating-increment function shared by match_cnt and drop_cnt.
- One sub-module, match_log_fifo: a synchronous DEPTH-entry FIFO of match_rec_t with push, pop, flush, full, empty and level. Read head is combinational from storage.
- Top level holds the ts counter, seq/match counters, overflow logic and push gating.

## Test plan
- Single match: after reset, en=1, match pulse at ts=5 → evt_valid next cycle, evt_ts=5, evt_seq=0, match_cnt=1.
- Fill/overflow: DEPTH=8, evt_ready=0, 10 matches → fifo_level=8, overflow=1, match_cnt=10. Drain yields evt_seq 0..7; drop_cnt=2 with the macro.
- Full with simultaneous push and pop: FIFO full, match and evt_ready=1 same cycle → level stays 8, overflow stays 0, new record is last.
- Gating: en=0 with 3 matches → no records, match_cnt unchanged. clr with match in same cycle → FIFO empty, match_cnt=0, next match has evt_seq=0.
- Wrap/saturate: TS_W=4, record at ts=15 then ts=0 → evt_ts 15, 0. CNT_W=4, 20 matches drained → match_cnt=15, evt_seq wraps 15→0.
- Mid-operation reset: rst with 3 entries queued and evt_valid=1, evt_ready=0 → next cycle evt_valid=0, fifo_level=0, overflow=0.
